// File: rtl/ps2_scancode_parser.sv
// PS/2 scan-code set 2 parser: pops bytes from the receiver FIFO, strips E0/F0 prefixes and
// emits one press/release event per key code, tracking the held key and a release counter.
module ps2_scancode_parser #(
  parameter int FILTER_REPEAT = 1,
  parameter int TIMEOUT_CYC   = 1000000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_nextdata_n,
  input  logic       rx_overflow,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       held_valid,
  output logic [7:0] held_code,
  output logic       held_ext,
  output logic [7:0] rel_cnt,
  output logic       err,
  input  logic       err_clr
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
  localparam bit FILT = (FILTER_REPEAT != 0);

  typedef enum logic [1:0] {S_IDLE, S_POP, S_GAP} state_t;

  state_t        state, state_d;
  logic          ext_q, brk_q;
  logic [TW-1:0] timer;

  logic is_e0, is_f0, is_disc, is_code;
  logic take, code_hit, make_fire, brk_fire, tmo_hit;

  assign is_e0   = (rx_data == 8'hE0);
  assign is_f0   = (rx_data == 8'hF0);
  assign is_disc = (rx_data == 8'hAA) || (rx_data == 8'hFA) || (rx_data == 8'hFE) ||
                   (rx_data == 8'hEE) || (rx_data == 8'h00) || (rx_data == 8'hFF);
  assign is_code = !(is_e0 || is_f0 || is_disc);

  // A code byte waits at the FIFO head while the previous event is still unaccepted.
  assign take      = (state == S_IDLE) && rx_ready && (!is_code || !ev_valid);
  assign code_hit  = held_valid && ({ext_q, rx_data} == {held_ext, held_code});
  assign make_fire = take && is_code && !brk_q && !(FILT && code_hit);
  assign brk_fire  = take && is_code && brk_q;
  assign tmo_hit   = !take && (ext_q || brk_q) && (timer == TMAX);

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (take) state_d = S_POP;
      S_POP:   state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state         <= S_IDLE;
      rx_nextdata_n <= 1'b1;
    end else begin
      state         <= state_d;
      rx_nextdata_n <= (state_d != S_POP);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ev_valid   <= 1'b0;
      ev_code    <= 8'h00;
      ev_ext     <= 1'b0;
      ev_break   <= 1'b0;
      held_valid <= 1'b0;
      held_code  <= 8'h00;
      held_ext   <= 1'b0;
      rel_cnt    <= 8'h00;
      err        <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      timer      <= '0;
    end else begin
      if (ev_valid && ev_ready) ev_valid <= 1'b0;
      if (make_fire || brk_fire) begin
        ev_valid <= 1'b1;
        ev_code  <= rx_data;
        ev_ext   <= ext_q;
        ev_break <= brk_q;
      end

      if (make_fire) begin
        held_valid <= 1'b1;
        held_code  <= rx_data;
        held_ext   <= ext_q;
      end else if (brk_fire && code_hit) begin
        held_valid <= 1'b0;
      end

      if (brk_fire) rel_cnt <= rel_cnt + 8'd1;

      // Prefix flags accumulate until a code byte consumes them or the timer drops them.
      if (take) begin
        timer <= '0;
        if (is_e0)        ext_q <= 1'b1;
        else if (is_f0)   brk_q <= 1'b1;
        else if (is_code) begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      end else if (ext_q || brk_q) begin
        if (timer == TMAX) begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          timer <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end else begin
        timer <= '0;
      end

      if (rx_overflow || tmo_hit) err <= 1'b1;
      else if (err_clr)           err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_parser.sv
// Bench for ps2_scancode_parser: FIFO model feeding byte streams, event scoreboard, table of
// byte sequences plus hand-written stall, timeout, error, reset and counter-wrap sequences.
module tb_ps2_scancode_parser;

  logic       clk = 1'b0;
  logic       clrn;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_nextdata_n;
  logic       rx_overflow;
  logic       ev_valid, ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext, ev_break;
  logic       held_valid;
  logic [7:0] held_code;
  logic       held_ext;
  logic [7:0] rel_cnt;
  logic       err, err_clr;

  logic       nr_nextdata_n, nr_ev_valid, nr_ev_ext, nr_ev_break;
  logic [7:0] nr_ev_code, nr_held_code, nr_rel_cnt;
  logic       nr_held_valid, nr_held_ext, nr_err;

  always #5 clk = ~clk;

  ps2_scancode_parser #(.FILTER_REPEAT(1), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .clrn(clrn), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_nextdata_n(rx_nextdata_n), .rx_overflow(rx_overflow),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_break(ev_break), .held_valid(held_valid), .held_code(held_code),
    .held_ext(held_ext), .rel_cnt(rel_cnt), .err(err), .err_clr(err_clr)
  );

  // Repeat-filter-off twin; shares the FIFO and stays in lockstep while ev_ready is held high.
  ps2_scancode_parser #(.FILTER_REPEAT(0), .TIMEOUT_CYC(16)) dut_nr (
    .clk(clk), .clrn(clrn), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_nextdata_n(nr_nextdata_n), .rx_overflow(rx_overflow),
    .ev_valid(nr_ev_valid), .ev_ready(1'b1), .ev_code(nr_ev_code), .ev_ext(nr_ev_ext),
    .ev_break(nr_ev_break), .held_valid(nr_held_valid), .held_code(nr_held_code),
    .held_ext(nr_held_ext), .rel_cnt(nr_rel_cnt), .err(nr_err), .err_clr(err_clr)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Receiver FIFO model
  logic [7:0] fifo_mem [256];
  int head = 0;
  int tail = 0;
  int pops = 0;
  assign rx_ready = (head != tail);
  assign rx_data  = fifo_mem[head[7:0]];

  always @(posedge clk)
    if (!rx_nextdata_n && head != tail) begin
      head <= head + 1;
      pops <= pops + 1;
    end

  task automatic push(input logic [7:0] b);
    fifo_mem[tail[7:0]] = b;
    tail = tail + 1;
  endtask

  // Scoreboard of {ext, brk, code}
  logic [9:0] exp_q [$];
  int nr_events = 0;

  always @(negedge clk) begin
    if (clrn && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL ev_unexpected: got %0h expected none", {ev_ext, ev_break, ev_code});
      end else begin
        chk("ev", {22'd0, ev_ext, ev_break, ev_code}, {22'd0, exp_q.pop_front()});
      end
    end
    if (clrn && nr_ev_valid) nr_events++;
  end

  task automatic drain(input string name);
    int k;
    k = 0;
    while (head != tail && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (head != tail) begin
      checks++;
      fails++;
      $display("FAIL %s: fifo not drained, %0d bytes left, required 0", name, tail - head);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_pop(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (rx_nextdata_n !== 1'b0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (rx_nextdata_n !== 1'b0) begin
      checks++;
      fails++;
      $display("FAIL %s: no pop strobe, rx_nextdata_n=%b required 0", name, rx_nextdata_n);
    end
  endtask

  typedef struct packed {
    logic [39:0] bytes;   // first byte in the top 8 bits
    logic [2:0]  n;
    logic        has_ev;
    logic        ext;
    logic        brk;
    logic [7:0]  code;
    logic        hv;
    logic        hext;
    logic [7:0]  hcode;
    logic [7:0]  rel;
  } vec_t;

  function automatic vec_t mk(input logic [39:0] bytes, input logic [2:0] n, input logic has_ev,
                              input logic ext, input logic brk, input logic [7:0] code,
                              input logic hv, input logic hext, input logic [7:0] hcode,
                              input logic [7:0] rel);
    vec_t v;
    v = '{bytes, n, has_ev, ext, brk, code, hv, hext, hcode, rel};
    return v;
  endfunction

  localparam int NV = 14;
  vec_t vec [NV];

  initial begin
    vec_t v;
    int   nbytes;
    int   p0;

    vec[0]  = mk(40'h1C00000000, 1, 1, 0, 0, 8'h1C, 1, 0, 8'h1C, 8'd0);
    vec[1]  = mk(40'hF01C000000, 2, 1, 0, 1, 8'h1C, 0, 0, 8'h1C, 8'd1);
    vec[2]  = mk(40'hE075000000, 2, 1, 1, 0, 8'h75, 1, 1, 8'h75, 8'd1);
    vec[3]  = mk(40'hE0F0750000, 3, 1, 1, 1, 8'h75, 0, 1, 8'h75, 8'd2);
    vec[4]  = mk(40'h1C00000000, 1, 1, 0, 0, 8'h1C, 1, 0, 8'h1C, 8'd2);
    vec[5]  = mk(40'h1C00000000, 1, 0, 0, 0, 8'h00, 1, 0, 8'h1C, 8'd2);
    vec[6]  = mk(40'h1C00000000, 1, 0, 0, 0, 8'h00, 1, 0, 8'h1C, 8'd2);
    vec[7]  = mk(40'hFA00000000, 1, 0, 0, 0, 8'h00, 1, 0, 8'h1C, 8'd2);
    vec[8]  = mk(40'hF0AA320000, 3, 1, 0, 1, 8'h32, 1, 0, 8'h1C, 8'd3);
    vec[9]  = mk(40'hF0E01C0000, 3, 1, 1, 1, 8'h1C, 1, 0, 8'h1C, 8'd4);
    vec[10] = mk(40'hE01C000000, 2, 1, 1, 0, 8'h1C, 1, 1, 8'h1C, 8'd4);
    vec[11] = mk(40'hF0F0E0E01C, 5, 1, 1, 1, 8'h1C, 0, 1, 8'h1C, 8'd5);
    vec[12] = mk(40'hF01C000000, 2, 1, 0, 1, 8'h1C, 0, 1, 8'h1C, 8'd6);
    vec[13] = mk(40'h1C00000000, 1, 1, 0, 0, 8'h1C, 1, 0, 8'h1C, 8'd6);

    clrn = 1'b0; ev_ready = 1'b1; rx_overflow = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", {1'b0, rx_nextdata_n, ev_valid, ev_ext, ev_break, ev_code, held_valid, held_ext,
                  held_code, rel_cnt, err}, {1'b0, 1'b1, 30'd0});
    clrn = 1'b1;
    @(posedge clk); #1;

    // Table of byte sequences; events checked by the scoreboard
    nbytes = 0;
    for (int i = 0; i < NV; i++) begin
      v = vec[i];
      if (v.has_ev) exp_q.push_back({v.ext, v.brk, v.code});
      for (int j = 0; j < int'(v.n); j++) push(v.bytes[39 - 8*j -: 8]);
      nbytes += int'(v.n);
      drain($sformatf("drain%0d", i));
      chk($sformatf("held%0d", i), {22'd0, held_valid, held_ext, held_code}, {22'd0, v.hv, v.hext, v.hcode});
      chk($sformatf("rel%0d", i), {24'd0, rel_cnt}, {24'd0, v.rel});
    end
    chk("pops_table", pops, nbytes);
    chk("nr_events", nr_events, 13);
    chk("err_table", {31'd0, err}, 32'd0);

    // Consumer stall: second code byte stays at the FIFO head
    ev_ready = 1'b0;
    p0 = pops;
    exp_q.push_back({2'b00, 8'h1B});
    exp_q.push_back({2'b00, 8'h32});
    push(8'h1B); push(8'h32);
    wait_pop("stall_pop");
    chk("latency", {23'd0, ev_valid, ev_code}, {23'd0, 1'b1, 8'h1B});
    repeat (20) @(posedge clk);
    #1;
    chk("stall_ev", {23'd0, ev_valid, ev_code}, {23'd0, 1'b1, 8'h1B});
    chk("stall_pops", pops - p0, 1);
    chk("stall_head", {22'd0, rx_nextdata_n, rx_ready, rx_data}, {22'd0, 1'b1, 1'b1, 8'h32});
    ev_ready = 1'b1;
    @(posedge clk); #1;
    ev_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stall_next", {23'd0, ev_valid, ev_code}, {23'd0, 1'b1, 8'h32});
    ev_ready = 1'b1;
    drain("stall_drain");
    chk("stall_held", {22'd0, held_valid, held_ext, held_code}, {22'd0, 1'b1, 1'b0, 8'h32});

    // Prefix timeout after exactly 16 cycles
    push(8'hE0);
    wait_pop("tmo_pop");
    repeat (15) @(posedge clk);
    #1;
    chk("tmo_before", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    chk("tmo_err", {31'd0, err}, 32'd1);
    exp_q.push_back({2'b00, 8'h1C});
    push(8'h1C);
    drain("tmo_drain");
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_clr", {31'd0, err}, 32'd0);

    // Overflow sets err; set wins over a simultaneous clear
    rx_overflow = 1'b1;
    @(posedge clk); #1;
    rx_overflow = 1'b0;
    chk("ovf_err", {31'd0, err}, 32'd1);
    rx_overflow = 1'b1; err_clr = 1'b1;
    @(posedge clk); #1;
    chk("ovf_set_wins", {31'd0, err}, 32'd1);
    rx_overflow = 1'b0;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("ovf_clr", {31'd0, err}, 32'd0);

    // Reset asserted while a byte is being popped
    ev_ready = 1'b0;
    push(8'h1D);
    wait_pop("rst_pop");
    clrn = 1'b0;
    #1;
    chk("rst_pop", {1'b0, rx_nextdata_n, ev_valid, ev_ext, ev_break, ev_code, held_valid, held_ext,
                    held_code, rel_cnt, err}, {1'b0, 1'b1, 30'd0});
    @(posedge clk); #1;
    clrn = 1'b1;
    ev_ready = 1'b1;
    exp_q.push_back({2'b00, 8'h1D});
    drain("rst_drain");
    chk("rst_held", {22'd0, held_valid, held_ext, held_code}, {22'd0, 1'b1, 1'b0, 8'h1D});

    // 256 releases wrap the counter back to 0
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back({2'b01, 8'h1D});
      push(8'hF0); push(8'h1D);
      drain("wrap_drain");
      if (i == 254) chk("rel_255", {24'd0, rel_cnt}, 32'd255);
    end
    chk("rel_wrap", {24'd0, rel_cnt}, 32'd0);
    chk("wrap_held", {31'd0, held_valid}, 32'd0);

    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
